// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with a two-stage pixel pipeline. It either passes
// frame-buffer pixels through or substitutes a built-in test pattern
// (colour bars, grid, solid grey).
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [1:0]  mode,
  input  logic [15:0] pix_in,
  output logic        req,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        active, hs_raw, vs_raw, at_origin;
  logic [1:0]  mode_q;

  logic        s1_valid_q, s1_de_q, s1_hs_q, s1_vs_q;
  logic [11:0] s1_x_q, s1_y_q;

  logic [2:0]  bar_idx;
  logic [15:0] bar_rgb, rgb_d;

  logic        hs_q, vs_q, de_q, fs_q;
  logic [11:0] x_q, y_q;
  logic [15:0] rgb_q;

  // Next raster position: h wraps at end of line and carries into v.
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_raw    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_raw    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign at_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  assign req       = active;

  // Raster counters, advancing one pixel per enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else if (pix_ce) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Pattern mode is sampled only at the frame origin so a frame never mixes modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 2'd0;
    end else if (pix_ce && at_origin) begin
      mode_q <= mode;
    end
  end

  // Stage 1 holds the requested position while the frame buffer answers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_de_q    <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_x_q     <= 12'd0;
      s1_y_q     <= 12'd0;
    end else if (pix_ce) begin
      s1_valid_q <= 1'b1;
      s1_de_q    <= active;
      s1_hs_q    <= hs_raw;
      s1_vs_q    <= vs_raw;
      s1_x_q     <= h_cnt_q;
      s1_y_q     <= v_cnt_q;
    end
  end

  // Colour-bar index by threshold comparison, avoiding a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (s1_x_q >= 12'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // Bar colours: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  // Pixel source selection; blanking always forces black.
  always_comb begin
    rgb_d = 16'h0000;
    if (s1_de_q) begin
      case (mode_q)
        2'd0:    rgb_d = pix_in;
        2'd1:    rgb_d = bar_rgb;
        2'd2:    rgb_d = ((s1_x_q[4:0] == 5'd0) || (s1_y_q[4:0] == 5'd0)) ? 16'hFFFF : 16'h0000;
        default: rgb_d = 16'h8410;
      endcase
    end
  end

  // Output registers, two enabled steps behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      x_q   <= 12'd0;
      y_q   <= 12'd0;
      rgb_q <= 16'h0000;
      fs_q  <= 1'b0;
    end else if (pix_ce) begin
      hs_q  <= s1_hs_q ? HS_POL : ~HS_POL;
      vs_q  <= s1_vs_q ? VS_POL : ~VS_POL;
      de_q  <= s1_de_q;
      x_q   <= s1_x_q;
      y_q   <= s1_y_q;
      rgb_q <= rgb_d;
      fs_q  <= s1_valid_q && (s1_x_q == 12'd0) && (s1_y_q == 12'd0);
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Directed bench for vga_timing_pattern_gen: a default 640x480 instance for
// line-level behaviour and a small instance (80x48 total, active-high syncs)
// for frame-level behaviour.
module tb_vga_timing_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [1:0]  mode;
  logic [15:0] pix_in;
  logic [15:0] pix_in_s;
  logic [11:0] mdl_h;

  logic        req, hs, vs, de, frame_start;
  logic [11:0] x, y;
  logic [15:0] rgb;

  logic        s_req, s_hs, s_vs, s_de, s_fs;
  logic [11:0] s_x, s_y;
  logic [15:0] s_rgb;

  int checks = 0;
  int errors = 0;

  vga_timing_pattern_gen dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .mode(mode), .pix_in(pix_in),
    .req(req), .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .rgb(rgb),
    .frame_start(frame_start)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .mode(mode), .pix_in(pix_in_s),
    .req(s_req), .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y), .rgb(s_rgb),
    .frame_start(s_fs)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Frame-buffer model: answers each enabled edge with {4'b0, column} of the pixel just requested.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_h  <= 12'd0;
      pix_in <= 16'h0000;
    end else if (pix_ce) begin
      pix_in <= {4'b0, mdl_h};
      mdl_h  <= (mdl_h == 12'd799) ? 12'd0 : mdl_h + 12'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse between edges, then release with pix_ce high.
  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1;
    mode = m;
    pix_ce = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] bar_colour(input int col);
    logic [15:0] tbl [8];
    tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    if (col >= 640) return 16'h0000;
    return tbl[col / 80];
  endfunction

  task automatic test_reset();
    rst = 1'b1; pix_ce = 1'b0; mode = 2'd0; pix_in_s = 16'hABCD;
    #2;
    checks++; if (de !== 1'b0) begin errors++; $display("[TB] FAIL reset_de: got %b expected 0", de); end
    checks++; if (hs !== 1'b1 || vs !== 1'b1) begin errors++; $display("[TB] FAIL reset_sync: got hs=%b vs=%b expected 1 1", hs, vs); end
    checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_pol: got hs=%b vs=%b expected 0 0", s_hs, s_vs); end
    checks++; if (x !== 12'd0 || y !== 12'd0 || rgb !== 16'h0 || frame_start !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outs: got x=%0d y=%0d rgb=%h fs=%b expected 0 0 0000 0", x, y, rgb, frame_start); end
    checks++; if (req !== 1'b1) begin errors++; $display("[TB] FAIL reset_req: got %b expected 1", req); end
    tick(); tick();
    checks++; if (de !== 1'b0 || x !== 12'd0) begin errors++; $display("[TB] FAIL reset_hold: got de=%b x=%0d expected 0 0", de, x); end
    rst = 1'b0; pix_ce = 1'b1;
    tick();
    checks++; if (de !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("[TB] FAIL edge1: got de=%b fs=%b expected 0 0", de, frame_start); end
    tick();
    checks++; if (de !== 1'b1 || x !== 12'd0 || y !== 12'd0 || frame_start !== 1'b1) begin
      errors++; $display("[TB] FAIL edge2: got de=%b x=%0d y=%0d fs=%b expected 1 0 0 1", de, x, y, frame_start); end
  endtask

  // Starts on the de-rise sample left by test_reset.
  task automatic test_line_timing();
    int de_hi = 0, hs_lo = 0, hs_first = -1, req_first_low = -1, xerr = 0;
    for (int i = 0; i <= 800; i++) begin
      if (i > 0) tick();
      if (i < 800) begin
        if (de === 1'b1) de_hi++;
        if (hs === 1'b0) begin hs_lo++; if (hs_first < 0) hs_first = i; end
        if (req === 1'b0 && req_first_low < 0) req_first_low = i;
        if (x !== 12'(i)) xerr++;
      end
    end
    checks++; if (de_hi != 640) begin errors++; $display("[TB] FAIL de_high_len: got %0d expected 640", de_hi); end
    checks++; if (hs_first != 656) begin errors++; $display("[TB] FAIL hs_start: got %0d expected 656", hs_first); end
    checks++; if (hs_lo != 96) begin errors++; $display("[TB] FAIL hs_len: got %0d expected 96", hs_lo); end
    checks++; if (req_first_low != 638) begin errors++; $display("[TB] FAIL req_fall: got %0d expected 638", req_first_low); end
    checks++; if (xerr != 0) begin errors++; $display("[TB] FAIL x_track: got %0d bad samples expected 0", xerr); end
    checks++; if (de !== 1'b1 || x !== 12'd0 || y !== 12'd1) begin
      errors++; $display("[TB] FAIL line_period: got de=%b x=%0d y=%0d expected 1 0 1", de, x, y); end
  endtask

  task automatic test_passthrough();
    int perr = 0, nact = 0;
    do_reset(2'd0);
    tick(); tick();
    for (int i = 0; i < 1600; i++) begin
      if (i > 0) tick();
      if (de === 1'b1) begin
        nact++;
        if (rgb !== {4'b0, x}) perr++;
      end else if (rgb !== 16'h0000) perr++;
    end
    checks++; if (perr != 0) begin errors++; $display("[TB] FAIL passthrough: got %0d bad pixels expected 0", perr); end
    checks++; if (nact != 1280) begin errors++; $display("[TB] FAIL passthrough_count: got %0d expected 1280", nact); end
  endtask

  task automatic test_colour_bars();
    logic [15:0] exp;
    logic        chk;
    int          blank_err = 0;
    do_reset(2'd1);
    tick(); tick();
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      chk = 1'b1;
      case (i)
        0, 79:    exp = 16'hFFFF;
        80:       exp = 16'hFFE0;
        160:      exp = 16'h07FF;
        240:      exp = 16'h07E0;
        320:      exp = 16'hF81F;
        400:      exp = 16'hF800;
        480:      exp = 16'h001F;
        560, 639: exp = 16'h0000;
        default: begin exp = 16'h0000; chk = 1'b0; end
      endcase
      if (chk) begin
        checks++;
        if (rgb !== exp) begin errors++; $display("[TB] FAIL bars_x%0d: got %h expected %h", i, rgb, exp); end
      end
      if (de === 1'b0 && rgb !== 16'h0000) blank_err++;
    end
    checks++; if (blank_err != 0) begin errors++; $display("[TB] FAIL bars_blank: got %0d nonzero expected 0", blank_err); end
  endtask

  task automatic test_pix_ce();
    int xerr = 0, cerr = 0, de_hi = 0, xe;
    do_reset(2'd1);
    tick();
    pix_ce = 1'b0; tick();
    pix_ce = 1'b1; tick();
    checks++; if (de !== 1'b1 || x !== 12'd0) begin errors++; $display("[TB] FAIL ce_rise: got de=%b x=%0d expected 1 0", de, x); end
    if (de === 1'b1) de_hi++;
    for (int i = 1; i <= 1600; i++) begin
      pix_ce = ~pix_ce;
      tick();
      xe = (i / 2) % 800;
      if (x !== 12'(xe)) xerr++;
      if (rgb !== bar_colour(xe)) cerr++;
      if (i < 1600 && de === 1'b1) de_hi++;
    end
    checks++; if (xerr != 0) begin errors++; $display("[TB] FAIL ce_x_seq: got %0d bad expected 0", xerr); end
    checks++; if (cerr != 0) begin errors++; $display("[TB] FAIL ce_rgb_seq: got %0d bad expected 0", cerr); end
    checks++; if (de_hi != 1280) begin errors++; $display("[TB] FAIL ce_de_len: got %0d expected 1280", de_hi); end
    checks++; if (de !== 1'b1 || y !== 12'd1) begin errors++; $display("[TB] FAIL ce_period: got de=%b y=%0d expected 1 1", de, y); end
    pix_ce = 1'b1;
  endtask

  task automatic test_reset_midline();
    do_reset(2'd1);
    tick(); tick();
    repeat (300) tick();
    checks++; if (de !== 1'b1 || x !== 12'd300) begin errors++; $display("[TB] FAIL mid_pre: got de=%b x=%0d expected 1 300", de, x); end
    #2 rst = 1'b1;
    #2;
    checks++; if (de !== 1'b0 || x !== 12'd0 || rgb !== 16'h0 || hs !== 1'b1 || frame_start !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_async: got de=%b x=%0d rgb=%h hs=%b fs=%b expected 0 0 0000 1 0", de, x, rgb, hs, frame_start); end
    #1 rst = 1'b0;
    tick();
    checks++; if (de !== 1'b0) begin errors++; $display("[TB] FAIL mid_edge1: got de=%b expected 0", de); end
    tick();
    checks++; if (de !== 1'b1 || x !== 12'd0 || frame_start !== 1'b1 || rgb !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL mid_edge2: got de=%b x=%0d fs=%b rgb=%h expected 1 0 1 FFFF", de, x, frame_start, rgb); end
  endtask

  task automatic test_frame_timing();
    int fs_cnt = 0, vs_cnt = 0, vs_first = -1, hs_first = -1, hs_cnt = 0, de_cnt = 0, perr = 0;
    do_reset(2'd0);
    tick(); tick();
    for (int i = 0; i <= 7680; i++) begin
      if (i > 0) tick();
      if (i < 7680 && s_fs === 1'b1) fs_cnt++;
      if (i < 3840) begin
        if (s_vs === 1'b1) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
        if (s_de === 1'b1) de_cnt++;
        if (s_x !== 12'(i % 80) || s_y !== 12'(i / 80)) perr++;
      end
      if (i < 80 && s_hs === 1'b1) begin hs_cnt++; if (hs_first < 0) hs_first = i; end
      if (i == 0) begin
        checks++; if (s_rgb !== 16'hABCD) begin errors++; $display("[TB] FAIL small_pass: got %h expected abcd", s_rgb); end
      end
      if (i == 70) begin
        checks++; if (s_rgb !== 16'h0000) begin errors++; $display("[TB] FAIL small_blank: got %h expected 0000", s_rgb); end
      end
      if (i == 3840 || i == 7680) begin
        checks++; if (s_fs !== 1'b1 || s_x !== 12'd0 || s_y !== 12'd0) begin
          errors++; $display("[TB] FAIL frame_period_%0d: got fs=%b x=%0d y=%0d expected 1 0 0", i, s_fs, s_x, s_y); end
      end
    end
    checks++; if (fs_cnt != 2) begin errors++; $display("[TB] FAIL fs_count: got %0d expected 2", fs_cnt); end
    checks++; if (vs_first != 3360 || vs_cnt != 160) begin errors++; $display("[TB] FAIL vs_timing: got start=%0d len=%0d expected 3360 160", vs_first, vs_cnt); end
    checks++; if (hs_first != 68 || hs_cnt != 8) begin errors++; $display("[TB] FAIL small_hs: got start=%0d len=%0d expected 68 8", hs_first, hs_cnt); end
    checks++; if (de_cnt != 2560) begin errors++; $display("[TB] FAIL small_de_count: got %0d expected 2560", de_cnt); end
    checks++; if (perr != 0) begin errors++; $display("[TB] FAIL small_xy: got %0d bad expected 0", perr); end
  endtask

  task automatic test_mode_switch();
    logic [15:0] exp;
    logic        chk;
    do_reset(2'd1);
    tick(); tick();
    for (int i = 0; i <= 6405; i++) begin
      if (i > 0) tick();
      if (i == 800) mode = 2'd2;
      chk = 1'b1;
      case (i)
        808:  exp = 16'hFFE0;
        3136: exp = 16'h07FF;
        3840: exp = 16'hFFFF;
        3925: exp = 16'h0000;
        3952: exp = 16'hFFFF;
        6405: exp = 16'hFFFF;
        default: begin exp = 16'h0000; chk = 1'b0; end
      endcase
      if (chk) begin
        checks++;
        if (s_rgb !== exp) begin errors++; $display("[TB] FAIL mode_switch_%0d: got %h expected %h", i, s_rgb, exp); end
      end
    end
    mode = 2'd0;
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_line_timing();
    test_passthrough();
    test_colour_bars();
    test_pix_ce();
    test_reset_midline();
    test_frame_timing();
    test_mode_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
